instr_encoder_loader: RTL and testbench

- Inverse of the core's opcode decoder: accepts symbolic instructions (mnemonic index, register fields, immediate) over a valid/ready handshake.
- Range-checks each instruction, packs it into the 32-bit ISA word and writes it sequentially into instruction memory through a write port.
- Serves as the boot/test program loader in front of the instruction memory.

---
 rtl/instr_encoder_loader_if.sv | 27 ++
 rtl/instr_encoder_loader.sv | 170 +++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Instruction-in / memory-write-out bus for the program loader.
// The loader sits on the slave side: it takes symbolic ops in and drives
// the instruction-memory write port out.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              op_valid;
  logic              op_ready;
  logic [4:0]        op_mnem;
  logic [3:0]        op_rd;
  logic [3:0]        op_rs1;
  logic [3:0]        op_rs2;
  logic [31:0]       op_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output op_valid, op_mnem, op_rd, op_rs1, op_rs2, op_imm,
    input  op_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  op_valid, op_mnem, op_rd, op_rs1, op_rs2, op_imm,
    output op_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Boot/test program loader: encodes symbolic instructions into 32-bit ISA
// words and writes them to consecutive instruction-memory addresses.
// Flow per op: IDLE (handshake) -> CHECK (decode, range check) -> WRITE.
// DEPTH must not exceed 2**ADDR_W.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  instr_encoder_loader_if.slave bus,
  output logic [ADDR_W:0]      instr_count,
  output logic                 full,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {IDLE, CHECK, WRITE} state_t;
  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_t;
  typedef enum logic [1:0] {IMM_NONE, IMM_S18, IMM_U18, IMM_U26} imm_t;

  state_t state, next_state;

  // Captured op fields (held through CHECK)
  logic [4:0]  mnem_q;
  logic [3:0]  rd_q, rs1_q, rs2_q;
  logic [31:0] imm_q;

  // Decode results
  logic [5:0]  opc;
  fmt_t        fmt;
  imm_t        imm_kind;
  logic        legal, imm_ok, zero_rs1, zero_rs2;
  logic [3:0]  rs1_eff, rs2_eff;
  logic [31:0] word;
  logic        accept;

  assign full   = (instr_count == DEPTH_C);
  assign accept = bus.op_valid && bus.op_ready;

  // Mnemonic -> opcode, word format and immediate class
  always_comb begin
    opc      = 6'b000000;
    fmt      = FMT_R;
    imm_kind = IMM_NONE;
    legal    = 1'b1;
    zero_rs1 = 1'b0;
    zero_rs2 = 1'b0;
    case (mnem_q)
      5'd0:  opc = 6'b000001;                                         // ADD
      5'd1:  begin opc = 6'b001001; fmt = FMT_I; imm_kind = IMM_S18; end // ADDI
      5'd2:  opc = 6'b000010;                                         // SUB
      5'd3:  begin opc = 6'b001010; fmt = FMT_I; imm_kind = IMM_S18; end // SUBI
      5'd4:  opc = 6'b000011;                                         // MUL
      5'd5:  begin opc = 6'b001011; fmt = FMT_I; imm_kind = IMM_S18; end // MULI
      5'd6:  begin opc = 6'b000100; zero_rs2 = 1'b1; end              // MOV
      5'd7:  begin opc = 6'b001100; fmt = FMT_I; imm_kind = IMM_S18; zero_rs1 = 1'b1; end // MOVI
      5'd8:  opc = 6'b010001;                                         // AND
      5'd9:  begin opc = 6'b011001; fmt = FMT_I; imm_kind = IMM_U18; end // ANDI
      5'd10: opc = 6'b010010;                                         // OR
      5'd11: begin opc = 6'b011010; fmt = FMT_I; imm_kind = IMM_U18; end // ORI
      5'd12: opc = 6'b010011;                                         // XOR
      5'd13: begin opc = 6'b010100; zero_rs2 = 1'b1; end              // NOT
      5'd14: begin opc = 6'b101001; fmt = FMT_I; imm_kind = IMM_U18; end // LDR
      5'd15: begin opc = 6'b101010; fmt = FMT_I; imm_kind = IMM_U18; end // LDA
      5'd16: begin opc = 6'b101011; fmt = FMT_I; imm_kind = IMM_U18; end // STR
      5'd17: begin opc = 6'b111000; fmt = FMT_J; imm_kind = IMM_U26; end // JMP
      5'd18: begin opc = 6'b111001; fmt = FMT_J; imm_kind = IMM_U26; end // JEQ
      5'd19: begin opc = 6'b111010; fmt = FMT_J; imm_kind = IMM_U26; end // JNEQ
      5'd20: begin opc = 6'b111011; fmt = FMT_J; imm_kind = IMM_U26; end // JGT
      5'd21: begin opc = 6'b111100; fmt = FMT_J; imm_kind = IMM_U26; end // JGE
      5'd22: begin opc = 6'b111101; fmt = FMT_J; imm_kind = IMM_U26; end // JLT
      default: legal = 1'b0;
    endcase
  end

  // Immediate range check: signed fits when the upper bits are a pure sign
  // extension of bit 17; unsigned fits when the upper bits are all zero.
  always_comb begin
    imm_ok = 1'b1;
    case (imm_kind)
      IMM_S18: imm_ok = (imm_q[31:17] == '0) || (imm_q[31:17] == '1);
      IMM_U18: imm_ok = (imm_q[31:18] == '0);
      IMM_U26: imm_ok = (imm_q[31:26] == '0);
      default: imm_ok = 1'b1;
    endcase
  end

  // Word packing; fields a format does not use are forced to zero
  always_comb begin
    rs1_eff = zero_rs1 ? 4'd0 : rs1_q;
    rs2_eff = zero_rs2 ? 4'd0 : rs2_q;
    word    = 32'd0;
    case (fmt)
      FMT_R:   word = {opc, rd_q, rs1_eff, rs2_eff, 14'd0};
      FMT_I:   word = {opc, rd_q, rs1_eff, imm_q[17:0]};
      FMT_J:   word = {opc, imm_q[25:0]};
      default: word = 32'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and handshake/strobe outputs; clr and rst mask both strobes
  // in the cycle they are asserted.
  always_comb begin
    next_state   = state;
    bus.op_ready = (state == IDLE) && !full && !clr && !rst;
    bus.imem_we  = (state == WRITE) && !clr && !rst;
    case (state)
      IDLE:    if (accept) next_state = CHECK;
      CHECK:   next_state = (legal && imm_ok) ? WRITE : IDLE;
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (clr) next_state = IDLE;
  end

  // Field capture, error reporting, write port registers and word counter.
  // Address/data are loaded on the CHECK->WRITE edge and then held.
  always_ff @(posedge clk) begin
    if (rst) begin
      mnem_q         <= '0;
      rd_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      imm_q          <= '0;
      err            <= 1'b0;
      err_code       <= 2'b00;
      instr_count    <= '0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        mnem_q <= bus.op_mnem;
        rd_q   <= bus.op_rd;
        rs1_q  <= bus.op_rs1;
        rs2_q  <= bus.op_rs2;
        imm_q  <= bus.op_imm;
      end
      if (clr) begin
        instr_count <= '0;
      end else begin
        if (state == CHECK) begin
          if (!legal) begin
            err      <= 1'b1;
            err_code <= 2'b01;
          end else if (!imm_ok) begin
            err      <= 1'b1;
            err_code <= 2'b10;
          end else begin
            err_code       <= 2'b00;
            bus.imem_addr  <= instr_count[ADDR_W-1:0];
            bus.imem_wdata <= word;
          end
        end
        if (state == WRITE) instr_count <= instr_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader (DEPTH overridden to 4). Expected writes
// are queued at handshake time with their due cycle and popped by a monitor.
module tb_instr_encoder_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst, clr;
  logic [ADDR_W:0] instr_count;
  logic full, err;
  logic [1:0] err_code;

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus),
    .instr_count(instr_count), .full(full), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                due;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  // Scoreboard monitor: every write strobe must match the oldest expectation
  always @(negedge clk) begin
    #2;
    if (bus.imem_we === 1'b1) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %h data %h at cycle %0d, nothing expected",
                 bus.imem_addr, bus.imem_wdata, cyc);
      end else begin
        mon_e = sbq.pop_front();
        if (bus.imem_addr !== mon_e.addr || bus.imem_wdata !== mon_e.data || cyc != mon_e.due) begin
          n_fail++;
          $display("FAIL write: got addr %h data %h cycle %0d, expected addr %h data %h cycle %0d",
                   bus.imem_addr, bus.imem_wdata, cyc, mon_e.addr, mon_e.data, mon_e.due);
        end
      end
    end
  end

  task automatic set_fields(input logic [4:0] m, input logic [3:0] rd, input logic [3:0] rs1,
                            input logic [3:0] rs2, input logic [31:0] imm);
    bus.op_mnem = m;
    bus.op_rd   = rd;
    bus.op_rs1  = rs1;
    bus.op_rs2  = rs2;
    bus.op_imm  = imm;
  endtask

  // Present one op and wait for its handshake; returns at the negedge of
  // the cycle after the handshake with op_valid dropped.
  task automatic send(input logic [4:0] m, input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, input logic [31:0] imm, input bit exp_wr,
                      input logic [ADDR_W-1:0] ea, input logic [31:0] ed, output int hc);
    bit got = 1'b0;
    hc = -1;
    @(negedge clk);
    set_fields(m, rd, rs1, rs2, imm);
    bus.op_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (bus.op_ready === 1'b1) begin
        got = 1'b1;
        hc  = cyc;
        if (exp_wr) sbq.push_back('{ea, ed, cyc + 2});
        @(posedge clk);
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    bus.op_valid = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL handshake_timeout: op %0d never accepted", m);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && sbq.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d writes still outstanding, expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0;
    bus.op_valid = 1'b0;
    set_fields(5'd0, 4'd0, 4'd0, 4'd0, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (bus.imem_we !== 1'b0 || bus.op_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: we %b ready %b, expected 0 0", bus.imem_we, bus.op_ready);
    end
    n_checks++;
    if (bus.imem_addr !== '0 || bus.imem_wdata !== '0) begin
      n_fail++; $display("FAIL reset_port: addr %h data %h, expected 0 0", bus.imem_addr, bus.imem_wdata);
    end
    n_checks++;
    if (instr_count !== '0 || full !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin
      n_fail++; $display("FAIL reset_status: cnt %0d full %b err %b code %b, expected 0 0 0 00",
                         instr_count, full, err, err_code);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.op_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b expected 1", bus.op_ready);
    end
  endtask

  task automatic test_encode();
    int hc;
    send(5'd0,  4'd1, 4'd2, 4'd3, 32'd0,        1'b1, 8'd0, 32'h0448C000, hc); // ADD
    send(5'd1,  4'd1, 4'd2, 4'd0, -32'sd5,      1'b1, 8'd1, 32'h244BFFFB, hc); // ADDI -5
    send(5'd17, 4'd0, 4'd0, 4'd0, 32'h100,      1'b1, 8'd2, 32'hE0000100, hc); // JMP
    wait_drain();
    n_checks++;
    if (instr_count !== 9'd3) begin
      n_fail++; $display("FAIL count_after_encode: got %0d expected 3", instr_count);
    end
  endtask

  task automatic test_errors();
    int hc;
    send(5'd1, 4'd1, 4'd2, 4'd0, 32'd131072, 1'b0, 8'd0, 32'd0, hc); // ADDI out of range
    @(negedge clk); #1;
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'b10) begin
      n_fail++; $display("FAIL range_err: err %b code %b, expected 1 10", err, err_code);
    end
    @(negedge clk); #1;
    n_checks++;
    if (err !== 1'b0 || err_code !== 2'b10 || instr_count !== 9'd3) begin
      n_fail++; $display("FAIL range_err_after: err %b code %b cnt %0d, expected 0 10 3",
                         err, err_code, instr_count);
    end
    send(5'd25, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0, 8'd0, 32'd0, hc); // illegal mnemonic
    @(negedge clk); #1;
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'b01) begin
      n_fail++; $display("FAIL illegal_err: err %b code %b, expected 1 01", err, err_code);
    end
    @(negedge clk); #1;
    n_checks++;
    if (err !== 1'b0 || err_code !== 2'b01 || instr_count !== 9'd3) begin
      n_fail++; $display("FAIL illegal_err_after: err %b code %b cnt %0d, expected 0 01 3",
                         err, err_code, instr_count);
    end
  endtask

  task automatic test_full();
    int hc;
    send(5'd11, 4'd1, 4'd1, 4'd0, 32'd5, 1'b1, 8'd3, 32'h68440005, hc); // ORI, last slot
    wait_drain();
    #1;
    n_checks++;
    if (full !== 1'b1 || bus.op_ready !== 1'b0 || instr_count !== 9'd4) begin
      n_fail++; $display("FAIL full: full %b ready %b cnt %0d, expected 1 0 4",
                         full, bus.op_ready, instr_count);
    end
    @(negedge clk);
    set_fields(5'd12, 4'd1, 4'd2, 4'd3, 32'd0); // XOR held while full
    bus.op_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (bus.op_ready !== 1'b0) begin
        n_fail++; $display("FAIL held_while_full: ready %b expected 0", bus.op_ready);
      end
      @(negedge clk);
    end
    clr = 1'b1;
    #1;
    n_checks++;
    if (bus.op_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_during_clr: got %b expected 0", bus.op_ready);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    n_checks++;
    if (instr_count !== 9'd0 || bus.op_ready !== 1'b1) begin
      n_fail++; $display("FAIL after_clr: cnt %0d ready %b, expected 0 1", instr_count, bus.op_ready);
    end
    sbq.push_back('{8'd0, 32'h4C48C000, cyc + 2});
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
    wait_drain();
    n_checks++;
    if (instr_count !== 9'd1) begin
      n_fail++; $display("FAIL count_after_refill: got %0d expected 1", instr_count);
    end
  endtask

  task automatic test_clr_with_valid();
    @(negedge clk);
    set_fields(5'd0, 4'd4, 4'd5, 4'd6, 32'd0);
    bus.op_valid = 1'b1;
    clr = 1'b1;
    #1;
    n_checks++;
    if (bus.op_ready !== 1'b0) begin
      n_fail++; $display("FAIL clr_valid_ready: got %b expected 0", bus.op_ready);
    end
    @(negedge clk);
    bus.op_valid = 1'b0;
    clr = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (instr_count !== 9'd0 || err !== 1'b0) begin
      n_fail++; $display("FAIL clr_valid_after: cnt %0d err %b, expected 0 0", instr_count, err);
    end
  endtask

  task automatic test_rst_in_check();
    int hc;
    send(5'd0, 4'd1, 4'd2, 4'd3, 32'd0, 1'b0, 8'd0, 32'd0, hc); // returns in CHECK
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (bus.imem_we !== 1'b0 || bus.op_ready !== 1'b0 || bus.imem_addr !== '0 ||
        bus.imem_wdata !== '0 || instr_count !== '0 || full !== 1'b0 ||
        err !== 1'b0 || err_code !== 2'b00) begin
      n_fail++; $display("FAIL rst_in_check: we %b rdy %b addr %h data %h cnt %0d full %b err %b code %b, expected all 0",
                         bus.imem_we, bus.op_ready, bus.imem_addr, bus.imem_wdata,
                         instr_count, full, err, err_code);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [4:0]  mm[3]  = '{5'd6, 5'd7, 5'd16};              // MOV, MOVI, STR
    logic [3:0]  rdv[3] = '{4'd5, 4'd3, 4'd2};
    logic [3:0]  r1v[3] = '{4'd6, 4'd9, 4'd4};
    logic [3:0]  r2v[3] = '{4'd7, 4'd0, 4'd0};
    logic [31:0] imv[3] = '{32'd0, 32'hFFFFFFFF, 32'd262143};
    logic [31:0] wv[3]  = '{32'h11580000, 32'h30C3FFFF, 32'hAC93FFFF};
    int hs[3];
    int k = 0;
    @(negedge clk);
    set_fields(mm[0], rdv[0], r1v[0], r2v[0], imv[0]);
    bus.op_valid = 1'b1;
    for (int i = 0; i < 40 && k < 3; i++) begin
      #1;
      if (bus.op_ready === 1'b1) begin
        hs[k] = cyc;
        sbq.push_back('{k[ADDR_W-1:0], wv[k], cyc + 2});
        @(posedge clk);
        @(negedge clk);
        k++;
        if (k < 3) set_fields(mm[k], rdv[k], r1v[k], r2v[k], imv[k]);
      end else begin
        @(negedge clk);
      end
    end
    bus.op_valid = 1'b0;
    n_checks++;
    if (k != 3) begin
      n_fail++; $display("FAIL b2b_accepts: got %0d expected 3", k);
    end else begin
      n_checks++;
      if (hs[1] - hs[0] != 3 || hs[2] - hs[1] != 3) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d,%0d expected 3,3", hs[1] - hs[0], hs[2] - hs[1]);
      end
    end
    wait_drain();
    n_checks++;
    if (instr_count !== 9'd3) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 3", instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_errors();
    test_full();
    test_clr_with_valid();
    test_rst_in_check();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
